// File: rtl/spi_slave_rx.sv
// SPI receive front-end: oversamples sclk/cs_n/mosi in the clk domain,
// assembles BITS-bit words and offers them on a valid/ready interface
// with single-cycle overrun and frame-error pulses.
module spi_slave_rx #(
   parameter int BITS      = 12,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sclk,
   input  logic            cs_n,
   input  logic            mosi,
   output logic [BITS-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            overrun,
   output logic            frame_err
);

   localparam int CW = $clog2(BITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

   // synchronizer chain; *_d_q is the extra delay stage used for edge detect
   logic sclk_s1_q, sclk_s_q, sclk_d_q;
   logic cs_s1_q, cs_s_q, cs_d_q;
   logic mosi_s1_q, mosi_s_q;

   logic rise;
   logic cs_rise;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] shift_q, shift_d;
   logic [BITS-1:0] dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;
   logic [BITS-1:0] word_nxt;
   logic            complete;

   assign rise    = sclk_s_q & ~sclk_d_q;
   assign cs_rise = cs_s_q & ~cs_d_q;

   // Two-flop synchronizers plus delay stage; idle-bus values on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_s1_q <= 1'b0;
         sclk_s_q  <= 1'b0;
         sclk_d_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s_q    <= 1'b1;
         cs_d_q    <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s_q  <= 1'b0;
      end else begin
         sclk_s1_q <= sclk;
         sclk_s_q  <= sclk_s1_q;
         sclk_d_q  <= sclk_s_q;
         cs_s1_q   <= cs_n;
         cs_s_q    <= cs_s1_q;
         cs_d_q    <= cs_s_q;
         mosi_s1_q <= mosi;
         mosi_s_q  <= mosi_s1_q;
      end
   end

   // Shift register contents with the current sampled bit merged in
   always_comb begin
      word_nxt = shift_q;
      if (LSB_FIRST) begin
         for (int i = 0; i < BITS; i++) begin
            if (cnt_q == CW'(i)) word_nxt[i] = mosi_s_q;
         end
      end else begin
         word_nxt = {shift_q[BITS-2:0], mosi_s_q};
      end
   end

   // Frame FSM, word completion and output-buffer handshake
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q & ~dout_ready;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
      complete     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            shift_d = '0;
            if (!cs_s_q) state_d = SHIFT;
         end
         SHIFT: begin
            // chip-select release takes priority over a coincident sclk rise
            if (cs_rise) begin
               frame_err_d = (cnt_q != '0);
               cnt_d       = '0;
               shift_d     = '0;
               state_d     = IDLE;
            end else if (rise) begin
               if (cnt_q == CW'(BITS - 1)) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  shift_d  = '0;
                  state_d  = DRAIN;
               end else begin
                  shift_d = word_nxt;
                  cnt_d   = cnt_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            // trailing sclk edges after a full word are ignored
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (complete) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = word_nxt;
            dout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: one LSB-first and one MSB-first instance share the
// same SPI bus and consumer-ready signal; a frame-level model predicts outputs.
module tb_spi_slave_rx;

   localparam int BITS = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic dout_ready = 1'b0;

   logic [BITS-1:0] dout0, dout1;
   logic dout_valid0, dout_valid1, overrun0, overrun1, frame_err0, frame_err1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   spi_slave_rx #(.BITS(BITS), .LSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
      .overrun(overrun0), .frame_err(frame_err0));

   spi_slave_rx #(.BITS(BITS), .LSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready),
      .overrun(overrun1), .frame_err(frame_err1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] rev12(input logic [11:0] v);
      logic [11:0] r;
      for (int i = 0; i < 12; i++) r[i] = v[11-i];
      return r;
   endfunction

   // ---------------- behavioural model + per-cycle compare ----------------
   logic [2:0] hs, hc, hm;          // raw-line history, bit0 newest
   int         mode;                // 0 waiting for cs, 1 collecting, 2 word done
   bit         q[$];                // bits received so far in this frame
   logic [11:0] e_dout0, e_dout1;
   bit         e_valid, e_ovr, e_ferr;

   logic [11:0] acc0[$], acc1[$];   // words the DUTs handed over
   int ovr_cnt = 0, ferr_cnt = 0, vcyc = 0;
   bit pv = 0;
   logic [11:0] pd0 = 0, pd1 = 0;

   initial begin
      bit rise, csr, csl, mb, done, loadable;
      logic [11:0] w0, w1;
      hs = 3'b000; hc = 3'b111; hm = 3'b000; mode = 0;
      e_dout0 = 0; e_dout1 = 0; e_valid = 0; e_ovr = 0; e_ferr = 0;
      forever begin
         @(posedge clk);
         if (rst_n && pv && dout_ready) begin
            acc0.push_back(pd0);
            acc1.push_back(pd1);
         end
         if (!rst_n) begin
            hs = 3'b000; hc = 3'b111; hm = 3'b000; mode = 0; q.delete();
            e_dout0 = 0; e_dout1 = 0; e_valid = 0; e_ovr = 0; e_ferr = 0;
         end else begin
            rise = hs[1] & ~hs[2];
            csr  = hc[1] & ~hc[2];
            csl  = ~hc[1];
            mb   = hm[1];
            e_ovr = 0; e_ferr = 0; done = 0;
            w0 = 0; w1 = 0;
            case (mode)
               0: if (csl) mode = 1;
               1: begin
                  if (csr) begin
                     if (q.size() > 0) e_ferr = 1;
                     q.delete();
                     mode = 0;
                  end else if (rise) begin
                     q.push_back(mb);
                     if (q.size() == BITS) begin
                        for (int i = 0; i < BITS; i++) begin
                           w0 = w0 | (12'(q[i]) << i);
                           w1 = w1 | (12'(q[i]) << (BITS - 1 - i));
                        end
                        done = 1;
                        q.delete();
                        mode = 2;
                     end
                  end
               end
               default: if (csr) mode = 0;
            endcase
            loadable = !e_valid || dout_ready;
            if (e_valid && dout_ready) e_valid = 0;
            if (done) begin
               if (loadable) begin
                  e_dout0 = w0; e_dout1 = w1; e_valid = 1;
               end else begin
                  e_ovr = 1;
               end
            end
            hs = {hs[1:0], sclk};
            hc = {hc[1:0], cs_n};
            hm = {hm[1:0], mosi};
         end
         #1;
         chk("dout0", dout0, e_dout0);
         chk("dout1", dout1, e_dout1);
         chk("valid0", dout_valid0, e_valid);
         chk("valid1", dout_valid1, e_valid);
         chk("overrun0", overrun0, e_ovr);
         chk("overrun1", overrun1, e_ovr);
         chk("frame_err0", frame_err0, e_ferr);
         chk("frame_err1", frame_err1, e_ferr);
         ovr_cnt  += int'(overrun0);
         ferr_cnt += int'(frame_err0);
         vcyc     += int'(dout_valid0);
         pv = dout_valid0; pd0 = dout0; pd1 = dout1;
      end
   end

   // ---------------- stimulus ----------------
   bit rnd_rdy = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
      end
   end

   // bit i of seq is the i-th bit on the wire
   task automatic send_frame(input logic [15:0] seq, input int n, input bit keep_cs,
                             input bit coincide, input bit rdy_last);
      int lo, hi;
      @(negedge clk);
      cs_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         mosi = seq[i];
         lo = 3 + $urandom_range(0, 2);
         hi = 3 + $urandom_range(0, 2);
         repeat (lo) @(negedge clk);
         sclk = 1'b1;
         if (coincide && i == n - 1) cs_n = 1'b1;
         for (int c = 0; c < hi; c++) begin
            @(negedge clk);
            if (rdy_last && i == n - 1 && c == 1) dout_ready = 1'b1;
         end
         sclk = 1'b0;
      end
      repeat (3) @(negedge clk);
      if (!keep_cs) begin
         cs_n = 1'b1;
         mosi = 1'b0;
         repeat (5) @(negedge clk);
      end
   endtask

   initial begin
      int o0, f0, v0;
      logic [15:0] v;
      int kind, n;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_dout", dout0, 12'h000);
      chk("rst_valid", dout_valid0, 1'b0);
      chk("rst_flags", {overrun0, frame_err0}, 2'b00);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // LSB-first word, consumer always ready
      dout_ready = 1'b1;
      o0 = ovr_cnt; f0 = ferr_cnt; v0 = vcyc;
      send_frame(16'hA5C, 12, 0, 0, 0);
      chk("lsb_word", acc0[$], 12'hA5C);
      chk("lsb_model", e_dout0, 12'hA5C);
      chk("lsb_valid_cycles", vcyc - v0, 1);
      chk("lsb_flags", (ovr_cnt - o0) + (ferr_cnt - f0), 0);

      // MSB-first word on the second instance
      send_frame({4'h0, rev12(12'h3C1)}, 12, 0, 0, 0);
      chk("msb_word", acc1[$], 12'h3C1);
      chk("msb_model", e_dout1, 12'h3C1);

      // overrun: buffer full, second word dropped
      dout_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(16'h111, 12, 0, 0, 0);
      send_frame(16'h222, 12, 0, 0, 0);
      chk("ovr_pulses", ovr_cnt - o0, 1);
      chk("ovr_dout_held", dout0, 12'h111);
      chk("ovr_dout_msb", dout1, 12'h888);
      chk("ovr_valid_held", dout_valid0, 1'b1);
      dout_ready = 1'b1;
      @(posedge clk); #1;
      chk("ovr_valid_drop", dout_valid0, 1'b0);
      chk("ovr_accepted", acc0[$], 12'h111);

      // ready arrives on the completion edge of the second word
      @(negedge clk);
      dout_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(16'h111, 12, 0, 0, 0);
      send_frame(16'h222, 12, 0, 0, 1);
      chk("edge_ovr", ovr_cnt - o0, 0);
      chk("edge_first", acc0[acc0.size()-2], 12'h111);
      chk("edge_second", acc0[$], 12'h222);

      // frame error after 5 bits, then a clean frame
      f0 = ferr_cnt;
      send_frame(16'h01F, 5, 0, 0, 0);
      chk("ferr_pulses", ferr_cnt - f0, 1);
      send_frame(16'h0F0, 12, 0, 0, 0);
      chk("ferr_next_word", acc0[$], 12'h0F0);

      // extra trailing sclk in one frame
      f0 = ferr_cnt; v0 = acc0.size();
      send_frame(16'h15A3, 13, 0, 0, 0);
      chk("extra_clk_ferr", ferr_cnt - f0, 0);
      chk("extra_clk_words", acc0.size() - v0, 1);
      chk("extra_clk_word", acc0[$], 12'h5A3);

      // reset mid-frame with a word held in dout
      dout_ready = 1'b0;
      send_frame(16'h777, 12, 0, 0, 0);
      send_frame(16'h02A, 6, 1, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_dout", dout0, 12'h000);
      chk("midrst_valid", {dout_valid0, dout_valid1}, 2'b00);
      chk("midrst_flags", {overrun0, frame_err0, overrun1, frame_err1}, 4'h0);
      repeat (2) @(negedge clk);
      cs_n = 1'b1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      dout_ready = 1'b1;
      send_frame(16'h3C5, 12, 0, 0, 0);
      chk("postrst_word", acc0[$], 12'h3C5);

      // randomized frames and consumer back-pressure
      rnd_rdy = 1;
      for (int k = 0; k < 40; k++) begin
         v = 16'($urandom);
         kind = $urandom_range(0, 5);
         case (kind)
            0: send_frame(v, $urandom_range(1, 11), 0, 0, 0);
            1: begin
               n = $urandom_range(1, 12);
               send_frame(v, n, 0, 1, 0);
            end
            2: send_frame(v, 13, 0, 0, 0);
            default: send_frame(v, 12, 0, 0, 0);
         endcase
      end
      rnd_rdy = 0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receive front-end that consumes the serial stream produced by the team's 12-bit SPI master (sclk, cs_n, mosi) and delivers completed words as parallel data. It runs in the system clock domain, oversampling the SPI lines through synchronizers. It presents each word on a valid/ready handshake to the downstream consumer, with overrun and frame-error flags.

Parameters:
BITS, 12, word length in bits (>=2)
LSB_FIRST, 1, 1 = first received bit lands in dout[0]; 0 = first bit lands in dout[BITS-1]

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
sclk  input  1  SPI serial clock, asynchronous to clk; data sampled on its rising edge
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  SPI serial data, asynchronous
dout  output  BITS  received word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when high with dout_valid
overrun  output  1  1-cycle pulse: word completed while buffer full; new word dropped
frame_err  output  1  1-cycle pulse: cs_n deasserted mid-word

Behaviour:
- Reset (rst_n low, async): dout=0, dout_valid=0, overrun=0, frame_err=0, bit counter=0, shift reg=0, state IDLE; sync flops preset to sclk=0, cs_n=1, mosi=0.
- Sync: each of sclk, cs_n, mosi passes through 2 flops; sclk and cs_n get a third delay flop. rise = sclk_s & ~sclk_d; cs_rise = cs_s & ~cs_d. "Event cycle" = cycle in which rise/cs_rise is 1.
- Timing requirement on source: sclk high and low phases each >= 3 clk periods; mosi stable from before sclk rise until after it.
- FSM states: IDLE, SHIFT, DRAIN.
- IDLE: counter=0. cs_s low -> SHIFT.
- SHIFT: on rise, sampled mosi_s captured at end of event cycle; LSB_FIRST=1 -> bit n goes to shift[n]; LSB_FIRST=0 -> shift left, new bit in LSB. Counter increments.
- On the BITS-th rise: word complete, same clock edge as the last shift; state -> DRAIN. Latency: dout_valid high 3 clk edges after raw sclk rise of last bit.
- Word delivery: if buffer empty (dout_valid=0) or being drained this cycle (dout_valid & dout_ready): dout <= word, dout_valid=1, no overrun. Else: word dropped, dout unchanged, overrun pulses 1 cycle.
- Handshake: transfer when dout_valid & dout_ready at a clock edge; dout_valid clears next edge unless a new word loads same edge. dout stable while dout_valid=1 and not accepted. dout_ready while dout_valid=0 has no effect.
- DRAIN: further sclk rises ignored (no shift, no error) until cs_rise -> IDLE. Covers the master's extra trailing clock.
- cs_rise while in SHIFT with counter in 1..BITS-1: frame_err 1-cycle pulse, partial word discarded, counter=0 -> IDLE. counter=0: -> IDLE, no error.
- rise and cs_rise in same cycle: cs_rise wins; bit not shifted.
- New frame: cs_n must go high then low; words never span frames. cs_n low at reset release -> SHIFT normally.
- Reset mid-frame: all state cleared immediately; a word in dout is lost.

Test Plan:
- LSB_FIRST=1, frame sends 0xA5C LSB first, dout_ready=1 -> dout=0xA5C, dout_valid high 1 cycle, no flags.
- LSB_FIRST=0, send 0x3C1 MSB first -> dout=0x3C1.
- dout_ready=0, two frames 0x111 then 0x222 -> dout stays 0x111, overrun pulses once at 2nd completion; ready=1 -> valid drops next cycle.
- Ready asserted on the exact edge the 2nd word completes -> 0x111 accepted, dout=0x222 valid, no overrun.
- cs_n raised after 5 bits, then full frame 0x0F0 -> frame_err pulses once, next dout=0x0F0 (no stale bits).
- 13 sclk rises in one frame (master's extra clock) -> single word, no frame_err; rst_n pulsed mid-frame -> all outputs 0, next full frame received correctly.
